// File: rtl/host_frame_receiver.sv
// host_frame_receiver: assembles SYNC/CTRL/D3..D0/CHK byte frames from the host
// serial receiver into a control byte and a 32-bit data word, holds them behind a
// dataReceived/clearDR handshake, and discards and counts malformed frames.
module host_frame_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        clearDR,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  output logic        frameError,
  output logic [7:0]  errorCount,
  output logic        rxBusy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter holds this value on the edge before it would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_D3, S_D2, S_D1, S_D0, S_CHK, S_HOLD
  } state_t;

  state_t           state_q;
  logic [7:0]       ctrl_sh_q;
  logic [31:0]      data_sh_q;
  logic [7:0]       xor_q;
  logic [CNT_W-1:0] tmo_q;
  logic             clr_q;

  logic in_frame_c;
  logic clr_rise_c;
  logic tmo_hit_c;
  logic err_c;

  // Decode the frame-in-progress window, clearDR edge and the one error cause per cycle.
  always_comb begin
    in_frame_c = (state_q != S_IDLE) && (state_q != S_HOLD);
    clr_rise_c = clearDR && !clr_q;
    tmo_hit_c  = in_frame_c && !rxValid && (tmo_q == CNT_LAST);
    err_c      = tmo_hit_c
               || ((state_q == S_CHK) && rxValid && (rxByte != xor_q))
               || ((state_q == S_HOLD) && rxValid);
  end

  // Frame state machine, shadow assembly, timeout counter and registered outputs.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ctrl_sh_q    <= 8'h00;
      data_sh_q    <= 32'h0;
      xor_q        <= 8'h00;
      tmo_q        <= '0;
      clr_q        <= 1'b0;
      dataReceived <= 1'b0;
      control      <= 8'h00;
      inputData    <= 32'h0;
      frameError   <= 1'b0;
      errorCount   <= 8'h00;
      rxBusy       <= 1'b0;
    end else begin
      clr_q      <= clearDR;
      frameError <= err_c;
      if (err_c && (errorCount != 8'hFF)) begin
        errorCount <= errorCount + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (rxValid && (rxByte == SYNC_BYTE)) begin
            state_q <= S_CTRL;
            xor_q   <= 8'h00;
            rxBusy  <= 1'b1;
          end
        end
        S_CTRL, S_D3, S_D2, S_D1, S_D0: begin
          if (rxValid) begin
            if (state_q == S_CTRL) begin
              ctrl_sh_q <= rxByte;
            end else begin
              data_sh_q <= {data_sh_q[23:0], rxByte};
            end
            xor_q   <= xor_q ^ rxByte;
            tmo_q   <= '0;
            state_q <= state_t'(state_q + 3'd1);
          end else if (tmo_hit_c) begin
            tmo_q   <= '0;
            state_q <= S_IDLE;
            rxBusy  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        S_CHK: begin
          if (rxValid) begin
            tmo_q  <= '0;
            rxBusy <= 1'b0;
            if (rxByte == xor_q) begin
              control      <= ctrl_sh_q;
              inputData    <= data_sh_q;
              dataReceived <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (tmo_hit_c) begin
            tmo_q   <= '0;
            state_q <= S_IDLE;
            rxBusy  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // Bytes arriving here are overruns, counted via err_c and dropped.
          tmo_q <= '0;
          if (clr_rise_c) begin
            dataReceived <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rxBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_frame_receiver.sv
// Scoreboard bench for host_frame_receiver: stimulus pushes expected frame and
// error events, a monitor pops them as the DUT raises dataReceived or frameError.
module tb_host_frame_receiver;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        clear_dr = 1'b0;
  logic        data_received;
  logic [7:0]  control;
  logic [31:0] input_data;
  logic        frame_error;
  logic [7:0]  error_count;
  logic        rx_busy;

  host_frame_receiver #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .masterClock (clk),
    .reset       (rst_n),
    .rxValid     (rx_valid),
    .rxByte      (rx_byte),
    .clearDR     (clear_dr),
    .dataReceived(data_received),
    .control     (control),
    .inputData   (input_data),
    .frameError  (frame_error),
    .errorCount  (error_count),
    .rxBusy      (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] exp_ecnt = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_err();
    exp_ecnt = (exp_ecnt == 8'hFF) ? 8'hFF : exp_ecnt + 8'd1;
    sb.push_back('{1'b1, 8'h00, 32'h0, exp_ecnt});
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [31:0] d);
    sb.push_back('{1'b0, c, d, exp_ecnt});
  endtask

  // Pop one expectation for the event the DUT just presented.
  task automatic sb_check(input bit is_err);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL sb_unexpected: got %s event ecnt=%0h with nothing expected",
               is_err ? "error" : "frame", error_count);
    end else begin
      e = sb.pop_front();
      if (e.is_err != is_err || e.ecnt !== error_count ||
          (!is_err && (e.ctrl !== control || e.data !== input_data))) begin
        n_miss++;
        $display("FAIL sb_%s: got err=%0d ctrl=%h data=%h ecnt=%h expected err=%0d ctrl=%h data=%h ecnt=%h",
                 is_err ? "error" : "frame", is_err, control, input_data, error_count,
                 e.is_err, e.ctrl, e.data, e.ecnt);
      end
    end
  endtask

  task automatic monitor();
    bit prev_dr = 1'b0;
    forever begin
      @(negedge clk);
      if (data_received && !prev_dr) sb_check(1'b0);
      if (frame_error) sb_check(1'b1);
      prev_dr = data_received;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d,
                            input logic [7:0] ck, input int gap);
    send_byte(8'hA5, gap);
    send_byte(c, gap);
    send_byte(d[31:24], gap);
    send_byte(d[23:16], gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
    send_byte(ck, 0);
  endtask

  task automatic release_frame(input string name);
    @(negedge clk);
    clear_dr = 1'b1;
    @(negedge clk);
    chk(name, 64'(data_received), 64'd0);
    @(negedge clk);
    clear_dr = 1'b0;
  endtask

  // Global time limit so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_err;
    fork
      monitor();
    join_none

    // Reset state
    idle(3);
    chk("reset_state", 64'({data_received, control, input_data, frame_error, error_count, rx_busy}), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: good frame, 4-cycle byte spacing, then release and repeat
    push_frame(8'h01, 32'hDEADBEEF);
    send_frame(8'h01, 32'hDEADBEEF, 8'h23, 3);
    chk("t1_dr_after_chk", 64'(data_received), 64'd1);
    chk("t1_busy_low", 64'(rx_busy), 64'd0);
    release_frame("t1_release");
    push_frame(8'h01, 32'hDEADBEEF);
    send_frame(8'h01, 32'hDEADBEEF, 8'h23, 3);
    chk("t1_second_frame", 64'(data_received), 64'd1);
    release_frame("t1_release2");

    // 2: bad checksum keeps the prior frame
    push_err();
    send_frame(8'h01, 32'hDEADBEEF, 8'h24, 1);
    idle(1);
    chk("t2_dr_low", 64'(data_received), 64'd0);
    chk("t2_retain", 64'({control, input_data}), 64'h01_DEADBEEF);
    chk("t2_ecnt", 64'(error_count), 64'd1);

    // 3: inter-byte timeout, error 15 edges after the DE byte is taken
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'hDE, 0);
    chk("t3_busy_high", 64'(rx_busy), 64'd1);
    push_err();
    first_err = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_error && first_err < 0) first_err = i;
    end
    chk("t3_timeout_latency", 64'(first_err), 64'd15);
    chk("t3_busy_low", 64'(rx_busy), 64'd0);
    push_frame(8'h10, 32'h12345678);
    send_frame(8'h10, 32'h12345678, 8'h18, 2);
    chk("t3_good_after", 64'({data_received, control, input_data}), 64'h1_10_12345678);
    release_frame("t3_release");

    // 4: clearDR high before HOLD is ignored; overruns in HOLD
    clear_dr = 1'b1;
    push_frame(8'h01, 32'hDEADBEEF);
    send_frame(8'h01, 32'hDEADBEEF, 8'h23, 1);
    idle(3);
    chk("t4_dr_held", 64'(data_received), 64'd1);
    for (int i = 0; i < 3; i++) begin
      push_err();
      send_byte(8'h55, 1);
    end
    chk("t4_held_data", 64'({data_received, control, input_data}), 64'h1_01_DEADBEEF);
    chk("t4_ecnt", 64'(error_count), 64'd5);
    clear_dr = 1'b0;
    idle(2);
    chk("t4_dr_after_low", 64'(data_received), 64'd1);
    clear_dr = 1'b1;
    @(negedge clk);
    chk("t4_dr_released", 64'(data_received), 64'd0);
    clear_dr = 1'b0;

    // 5: garbage before sync, then overrun coinciding with release
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h13, 1);
    idle(2);
    chk("t5_no_garbage_err", 64'(error_count), 64'd5);
    push_frame(8'h02, 32'h0000002A);
    send_frame(8'h02, 32'h0000002A, 8'h28, 1);
    chk("t5_frame", 64'({data_received, control, input_data}), 64'h1_02_0000002A);
    push_err();
    @(negedge clk);
    clear_dr = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h77;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t5_release_with_overrun", 64'(data_received), 64'd0);
    clear_dr = 1'b0;
    idle(1);

    // 6: saturation, then reset mid-frame
    for (int i = 0; i < 260; i++) begin
      push_err();
      send_frame(8'h01, 32'hDEADBEEF, 8'h24, 0);
    end
    idle(2);
    chk("t6_saturated", 64'(error_count), 64'hFF);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    rst_n = 1'b0;
    idle(2);
    chk("t6_reset_mid", 64'({data_received, control, input_data, frame_error, error_count, rx_busy}), 64'd0);
    exp_ecnt = 8'h00;
    rst_n = 1'b1;
    idle(1);
    push_frame(8'h01, 32'hDEADBEEF);
    send_frame(8'h01, 32'hDEADBEEF, 8'h23, 0);
    chk("t6_frame_after_reset", 64'({data_received, control, input_data, error_count}), 64'h1_01_DEADBEEF_00);
    release_frame("t6_release");

    idle(20);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
